// File: rtl/instr_loader.sv
// Boot-time program loader: packs a little-endian byte stream into 32-bit words
// and writes them to instruction RAM while holding the CPU off.
module instr_loader #(
    parameter int MEM_SIZE = 1024,
    parameter int NW_W     = $clog2(MEM_SIZE / 4) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [NW_W-1:0] num_words,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            mem_wr_en,
    output logic [63:0]     mem_wr_addr,
    output logic [31:0]     mem_wr_data,
    output logic            cpu_hold,
    output logic            done,
    output logic            error
);

    localparam logic [NW_W-1:0] CAPACITY = NW_W'(MEM_SIZE / 4);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        DONE    = 3'd3,
        ERR     = 3'd4
    } state_t;

    state_t          state_r;
    logic [1:0]      byte_cnt_r;
    logic [NW_W-1:0] word_idx_r;
    logic [NW_W-1:0] num_words_r;
    logic [23:0]     shift_r;     // first three bytes of the word, byte 0 at LSB

    // Loader FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            byte_cnt_r  <= 2'd0;
            word_idx_r  <= '0;
            num_words_r <= '0;
            shift_r     <= 24'd0;
            in_ready    <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= 64'd0;
            mem_wr_data <= 32'd0;
            cpu_hold    <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        done        <= 1'b0;
                        error       <= 1'b0;
                        word_idx_r  <= '0;
                        byte_cnt_r  <= 2'd0;
                        num_words_r <= num_words;
                        if (num_words > CAPACITY) begin
                            state_r <= ERR;
                            error   <= 1'b1;
                        end else if (num_words == '0) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r  <= COLLECT;
                            in_ready <= 1'b1;
                            cpu_hold <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (in_valid && in_ready) begin
                        shift_r    <= {in_data, shift_r[23:8]};
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            // Fourth byte completes the word: present it next cycle.
                            state_r     <= WRITE;
                            in_ready    <= 1'b0;
                            mem_wr_en   <= 1'b1;
                            mem_wr_addr <= 64'({word_idx_r, 2'b00});
                            mem_wr_data <= {in_data, shift_r};
                        end
                    end
                end
                WRITE: begin
                    mem_wr_en  <= 1'b0;
                    word_idx_r <= word_idx_r + NW_W'(1);
                    if ((word_idx_r + NW_W'(1)) == num_words_r) begin
                        state_r  <= DONE;
                        cpu_hold <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        state_r  <= COLLECT;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b0;
                    mem_wr_en <= 1'b0;
                    cpu_hold  <= 1'b0;
                    done      <= 1'b0;
                    error     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: byte streams with hand-computed words,
// capacity limits, zero length, async reset mid-word and ignored start.
module tb_instr_loader;
    localparam int MEM_SIZE = 1024;
    localparam int NW_W     = $clog2(MEM_SIZE / 4) + 1;

    logic            clk = 1'b0;
    logic            reset, start, in_valid;
    logic [NW_W-1:0] num_words;
    logic [7:0]      in_data;
    logic            in_ready, mem_wr_en, cpu_hold, done, error;
    logic [63:0]     mem_wr_addr;
    logic [31:0]     mem_wr_data;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   t0    = 0;
    logic prev_en = 1'b0;
    logic [63:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  stream[8] = '{8'h8B, 8'h00, 8'h1F, 8'h91, 8'h20, 8'h00, 8'h00, 8'h14};

    instr_loader #(.MEM_SIZE(MEM_SIZE), .NW_W(NW_W)) dut (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Write-port monitor: records every write and checks its invariants.
    always @(negedge clk) begin
        if (mem_wr_en) begin
            chk("wr_one_cycle", {63'd0, prev_en}, 64'd0);
            chk("rdy_in_write", {63'd0, in_ready}, 64'd0);
            chk("hold_in_write", {63'd0, cpu_hold}, 64'd1);
            chk("addr_bound", {63'd0, (mem_wr_addr + 64'd3) < 64'(MEM_SIZE)}, 64'd1);
            wa_q.push_back(mem_wr_addr);
            wd_q.push_back(mem_wr_data);
        end
        prev_en = mem_wr_en;
    end

    task automatic start_load(input int n);
        start     = 1'b1;
        num_words = NW_W'(n);
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("ready_wait", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (!(done || error) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("done_wait", {63'd0, done}, 64'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; num_words = '0; in_data = 8'd0; in_valid = 1'b0;
        #12;
        chk("rst_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_wr_en", {63'd0, mem_wr_en}, 64'd0);
        chk("rst_addr", mem_wr_addr, 64'd0);
        chk("rst_data", {32'd0, mem_wr_data}, 64'd0);
        chk("rst_flags", {60'd0, cpu_hold, done, error, 1'b0}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Basic load, continuous stream
        start_load(2);
        chk("t1_hold", {63'd0, cpu_hold}, 64'd1);
        for (int i = 0; i < 8; i++) send_byte(stream[i], 1'b0);
        wait_done(20);
        chk("t1_latency", 64'(cyc - t0), 64'd10);
        chk("t1_hold_off", {63'd0, cpu_hold}, 64'd0);
        chk("t1_nwr", 64'(wa_q.size()), 64'd2);
        chk("t1_a0", wa_q[0], 64'd0);
        chk("t1_d0", {32'd0, wd_q[0]}, 64'h911F008B);
        chk("t1_a1", wa_q[1], 64'd4);
        chk("t1_d1", {32'd0, wd_q[1]}, 64'h14000020);

        // Same stream with in_valid gaps
        wa_q.delete(); wd_q.delete();
        start_load(2);
        chk("t2_done_clr", {63'd0, done}, 64'd0);
        for (int i = 0; i < 8; i++) send_byte(stream[i], 1'b1);
        wait_done(40);
        chk("t2_nwr", 64'(wa_q.size()), 64'd2);
        chk("t2_a1", wa_q[1], 64'd4);
        chk("t2_d0", {32'd0, wd_q[0]}, 64'h911F008B);
        chk("t2_d1", {32'd0, wd_q[1]}, 64'h14000020);

        // Over capacity
        wa_q.delete(); wd_q.delete();
        start_load(257);
        chk("t3_err", {63'd0, error}, 64'd1);
        chk("t3_done", {63'd0, done}, 64'd0);
        chk("t3_hold", {63'd0, cpu_hold}, 64'd0);
        repeat (5) @(negedge clk);
        chk("t3_ready", {63'd0, in_ready}, 64'd0);
        chk("t3_nwr", 64'(wa_q.size()), 64'd0);

        // Full capacity
        start_load(256);
        chk("t3_err_clr", {63'd0, error}, 64'd0);
        for (int i = 0; i < 1024; i++) send_byte(8'(i), 1'b0);
        wait_done(20);
        chk("t3_full_nwr", 64'(wa_q.size()), 64'd256);
        chk("t3_full_d1", {32'd0, wd_q[1]}, 64'h07060504);
        chk("t3_last_a", wa_q[255], 64'd1020);
        chk("t3_last_d", {32'd0, wd_q[255]}, 64'hFFFEFDFC);

        // Zero length
        wa_q.delete(); wd_q.delete();
        start_load(0);
        chk("t4_done", {63'd0, done}, 64'd1);
        chk("t4_ready", {63'd0, in_ready}, 64'd0);
        repeat (3) @(negedge clk);
        chk("t4_nwr", 64'(wa_q.size()), 64'd0);

        // Reset after two bytes of word 1
        start_load(3);
        for (int i = 0; i < 6; i++) send_byte(stream[i], 1'b0);
        reset = 1'b1;
        #1;
        chk("t5_rst_ready", {63'd0, in_ready}, 64'd0);
        chk("t5_rst_hold", {63'd0, cpu_hold}, 64'd0);
        chk("t5_rst_wr", {63'd0, mem_wr_en}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_nwr_rst", 64'(wa_q.size()), 64'd1);
        start_load(1);
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
        wait_done(20);
        chk("t5_nwr", 64'(wa_q.size()), 64'd2);
        chk("t5_a", wa_q[1], 64'd0);
        chk("t5_d", {32'd0, wd_q[1]}, 64'h44332211);

        // Start ignored mid-COLLECT
        wa_q.delete(); wd_q.delete();
        start_load(2);
        send_byte(stream[0], 1'b0); send_byte(stream[1], 1'b0);
        start_load(5);
        for (int i = 2; i < 8; i++) send_byte(stream[i], 1'b0);
        wait_done(20);
        repeat (10) @(negedge clk);
        chk("t6_nwr", 64'(wa_q.size()), 64'd2);
        chk("t6_done", {63'd0, done}, 64'd1);
        chk("t6_d1", {32'd0, wd_q[1]}, 64'h14000020);
        start_load(1);
        chk("t6_done_clr", {63'd0, done}, 64'd0);
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0); send_byte(8'hDD, 1'b0);
        wait_done(20);
        chk("t6_restart_a", wa_q[2], 64'd0);
        chk("t6_restart_d", {32'd0, wd_q[2]}, 64'hDDCCBBAA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
